// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: host write FIFO feeding a frame FSM with
// configurable data width, parity, stop bits and a per-frame baud divider.
module uart_tx_fifo_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic                 Tx_WR,
    input  logic                 Tx_EN,
    input  logic [2:0]           baud_select,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 Tx_D,
    output logic                 Tx_BUSY,
    output logic                 Tx_FULL,
    output logic                 Tx_OVF
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_DEPTH = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [31:0]        OS_M1     = 32'(OVERSAMPLE - 1);
    localparam logic [3:0]         LAST_BIT  = 4'(DATA_BITS - 1);

    function automatic logic [31:0] div_of(input int s);
        longint baud, den, d;
        case (s)
            0:       baud = 300;
            1:       baud = 1200;
            2:       baud = 4800;
            3:       baud = 9600;
            4:       baud = 19200;
            5:       baud = 38400;
            6:       baud = 57600;
            default: baud = 115200;
        endcase
        den = longint'(OVERSAMPLE) * baud;
        d   = (longint'(CLK_HZ) + den / 2) / den;
        return (d < 1) ? 32'd1 : 32'(d);
    endfunction

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 full, empty, push, pop, ovf;
    logic [DATA_BITS-1:0] head;

    state_t               state;
    logic                 tx_d, en_q, par_en, par_bit, stop2_q;
    logic [DATA_BITS-1:0] sh;
    logic [3:0]           bit_idx;
    logic [31:0]          div_q, div_cnt, os_cnt, div_new;
    logic                 tick, bit_end, last_stop;

    assign full  = (count == CNT_DEPTH);
    assign empty = (count == '0);
    assign push  = Tx_WR && !full;
    assign head  = mem[rd_ptr];

    always_comb begin
        case (baud_select)
            3'd0:    div_new = div_of(0);
            3'd1:    div_new = div_of(1);
            3'd2:    div_new = div_of(2);
            3'd3:    div_new = div_of(3);
            3'd4:    div_new = div_of(4);
            3'd5:    div_new = div_of(5);
            3'd6:    div_new = div_of(6);
            default: div_new = div_of(7);
        endcase
    end

    always_comb begin
        tick      = (div_cnt == div_q - 32'd1);
        bit_end   = (state != IDLE) && tick && (os_cnt == OS_M1);
        last_stop = (state == STOP) && (!stop2_q || bit_idx[0]);
        // A new frame loads either from idle or on the final cycle of the stop bit(s).
        pop       = !empty && en_q && ((state == IDLE) || (bit_end && last_stop));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Tx_DATA;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            if (Tx_WR && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx_d    <= 1'b1;
            en_q    <= 1'b0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            stop2_q <= 1'b0;
            sh      <= '0;
            bit_idx <= '0;
            div_q   <= 32'd1;
            div_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            en_q <= Tx_EN;
            if (state != IDLE) begin
                div_cnt <= tick ? 32'd0 : div_cnt + 32'd1;
                if (tick) os_cnt <= (os_cnt == OS_M1) ? 32'd0 : os_cnt + 32'd1;
            end
            if (pop) begin
                // Config is captured here so mid-frame changes only affect later frames.
                state   <= START;
                tx_d    <= 1'b0;
                div_cnt <= '0;
                os_cnt  <= '0;
                sh      <= head;
                par_bit <= (^head) ^ (parity_mode == 2'b10);
                par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                stop2_q <= stop2;
                div_q   <= div_new;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx_d    <= sh[0];
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                state <= PARITY;
                                tx_d  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_d  <= 1'b1;
                            end
                        end else begin
                            sh      <= sh >> 1;
                            tx_d    <= sh[1];
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        tx_d    <= 1'b1;
                        bit_idx <= '0;
                    end
                    STOP: begin
                        if (last_stop) state <= IDLE;
                        else           bit_idx <= bit_idx + 4'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Tx_D    = tx_d;
    assign Tx_BUSY = (state != IDLE) || !empty;
    assign Tx_FULL = full;
    assign Tx_OVF  = ovf;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: a line monitor checks every cycle of each frame
// against an expected-frame queue; directed tables and sequences cover timing corners.
module tb_uart_tx_fifo_param;
    localparam int CLK_HZ = 10_000_000;
    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int AW     = 2;

    logic          clk = 1'b0, reset = 1'b0;
    logic [DB-1:0] Tx_DATA = '0;
    logic          Tx_WR = 1'b0, Tx_EN = 1'b0, stop2 = 1'b0;
    logic [2:0]    baud_select = 3'd7;
    logic [1:0]    parity_mode = 2'd0;
    logic          Tx_D, Tx_BUSY, Tx_FULL, Tx_OVF;

    uart_tx_fifo_param #(.CLK_HZ(CLK_HZ), .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .baud_select(baud_select), .parity_mode(parity_mode), .stop2(stop2),
        .Tx_D(Tx_D), .Tx_BUSY(Tx_BUSY), .Tx_FULL(Tx_FULL), .Tx_OVF(Tx_OVF));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0, nerr = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic [1:0]    par;
        logic          st2;
        logic [2:0]    baud;
    } frame_t;

    typedef struct {
        logic [DB-1:0] data;
        logic [1:0]    par;
        logic          st2;
        logic [2:0]    baud;
        int            len;
        int            pb;
    } vec_t;

    frame_t exp_q[$];
    int     start_q[$];
    int     mon_busy = 0;

    task automatic chkn(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Bit period from the baud rate: OVERSAMPLE * rounded divider, never below one.
    function automatic int per(input logic [2:0] b);
        int baud, d;
        case (b)
            3'd0: baud = 300;    3'd1: baud = 1200;  3'd2: baud = 4800;  3'd3: baud = 9600;
            3'd4: baud = 19200;  3'd5: baud = 38400; 3'd6: baud = 57600; default: baud = 115200;
        endcase
        d = (CLK_HZ + OS * baud / 2) / (OS * baud);
        if (d < 1) d = 1;
        return OS * d;
    endfunction

    function automatic int nbits(input frame_t f);
        return 1 + DB + ((f.par == 2'd1 || f.par == 2'd2) ? 1 : 0) + 1 + (f.st2 ? 1 : 0);
    endfunction

    function automatic logic lvl(input frame_t f, input int j);
        if (j == 0) return 1'b0;
        if (j <= DB) return f.data[j-1];
        if ((f.par == 2'd1 || f.par == 2'd2) && j == DB + 1) return (^f.data) ^ (f.par == 2'd2);
        return 1'b1;
    endfunction

    frame_t mf;
    int     mp, mn, bad, bj, bk, aborted;
    logic   bact;

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && Tx_D === 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_frame at cycle %0d: got start bit, required none", cyc);
                    for (int t = 0; t < 30000 && Tx_BUSY !== 1'b0; t++) @(negedge clk);
                end else begin
                    mon_busy = 1;
                    mf = exp_q.pop_front();
                    mp = per(mf.baud); mn = nbits(mf); bad = 0; aborted = 0;
                    for (int j = 0; j < mn && aborted == 0; j++)
                        for (int k = 0; k < mp && aborted == 0; k++) begin
                            if (j != 0 || k != 0) @(negedge clk);
                            if (reset !== 1'b1) aborted = 1;
                            else if (bad == 0 && Tx_D !== lvl(mf, j)) begin
                                bad = 1; bj = j; bk = k; bact = Tx_D;
                            end
                        end
                    if (aborted == 0) begin
                        nchk++;
                        if (bad != 0) begin
                            nerr++;
                            $display("FAIL frame data=%h bit %0d cycle %0d: got Tx_D=%b, required %b",
                                     mf.data, bj, bk, bact, lvl(mf, bj));
                        end
                    end
                    mon_busy = 0;
                end
            end
        end
    end

    task automatic wr(input logic [DB-1:0] d, output int n);
        @(posedge clk); #1;
        Tx_DATA = d; Tx_WR = 1'b1; n = cyc;
        @(posedge clk); #1;
        Tx_WR = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int done = 0;
        for (int t = 0; t < budget && done == 0; t++) begin
            @(negedge clk);
            if (Tx_BUSY === 1'b0 && mon_busy == 0 && exp_q.size() == 0) done = 1;
        end
        chkn("idle_reached", done, 1);
        if (done == 0) exp_q.delete();
    endtask

    task automatic find_fall(input int budget, output int c);
        c = -1;
        for (int t = 0; t < budget && c < 0; t++) begin
            @(negedge clk);
            if (Tx_D === 1'b0) c = cyc;
        end
    endtask

    task automatic wait_start(input int budget);
        for (int t = 0; t < budget && start_q.size() == 0; t++) @(negedge clk);
        chkn("frame_started", (start_q.size() > 0) ? 1 : 0, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish, required finish before cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vt[6];
    int   n, fall, low, m, fc, fd, nb;
    logic [DB-1:0] d;

    initial begin
        vt[0] = '{8'hA5, 2'd0, 1'b0, 3'd7,  800, -1};
        vt[1] = '{8'h03, 2'd1, 1'b0, 3'd7,  880,  0};
        vt[2] = '{8'h03, 2'd2, 1'b0, 3'd7,  880,  1};
        vt[3] = '{8'h03, 2'd1, 1'b1, 3'd7,  960,  0};
        vt[4] = '{8'h5A, 2'd0, 1'b1, 3'd6, 1936, -1};
        vt[5] = '{8'hFF, 2'd2, 1'b0, 3'd5, 2816,  1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_Tx_D", Tx_D, 1'b1);
        chk1("reset_BUSY", Tx_BUSY, 1'b0);
        chk1("reset_FULL", Tx_FULL, 1'b0);
        chk1("reset_OVF", Tx_OVF, 1'b0);
        reset = 1'b1;
        Tx_EN = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            parity_mode = vt[i].par; stop2 = vt[i].st2; baud_select = vt[i].baud;
            exp_q.push_back('{vt[i].data, vt[i].par, vt[i].st2, vt[i].baud});
            wr(vt[i].data, n);
            find_fall(50, fall);
            chkn("latency", fall - n, 2);
            if (vt[i].pb >= 0) begin
                while (cyc < fall + (1 + DB) * per(vt[i].baud) + per(vt[i].baud) / 2) @(negedge clk);
                chk1("parity_bit", Tx_D, vt[i].pb[0]);
            end
            low = -1;
            for (int t = 0; t < 20000 && low < 0; t++) begin
                @(negedge clk);
                if (Tx_BUSY === 1'b0) low = cyc;
            end
            chkn("frame_len", low - fall, vt[i].len);
            wait_idle(100);
        end

        // FIFO fill with transmission held off, then back-to-back drain.
        parity_mode = 2'd0; stop2 = 1'b0; baud_select = 3'd7;
        Tx_EN = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            wr(8'h10 + 8'(i), n);
            if (i < 4) exp_q.push_back('{8'h10 + 8'(i), 2'd0, 1'b0, 3'd7});
            chk1("fill_FULL", Tx_FULL, (i >= 3));
        end
        chk1("ovf_set", Tx_OVF, 1'b1);
        repeat (20) @(negedge clk);
        chk1("held_BUSY", Tx_BUSY, 1'b1);
        chk1("held_Tx_D", Tx_D, 1'b1);
        start_q.delete();
        @(posedge clk); #1;
        Tx_EN = 1'b1; m = cyc; fc = -1; fd = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (fc < 0 && Tx_FULL === 1'b0) fc = cyc;
            if (fd < 0 && Tx_D === 1'b0) fd = cyc;
        end
        chkn("full_clear_lat", fc - m, 2);
        chkn("enable_start_lat", fd - m, 2);
        wait_idle(5000);
        chkn("drain_frames", start_q.size(), 4);
        if (start_q.size() == 4)
            for (int i = 1; i < 4; i++) chkn("no_gap", start_q[i] - start_q[i-1], 800);
        chk1("ovf_sticky", Tx_OVF, 1'b1);

        // Disable mid-frame with one byte still queued.
        start_q.delete();
        exp_q.push_back('{8'h3C, 2'd0, 1'b0, 3'd7});
        exp_q.push_back('{8'hC3, 2'd0, 1'b0, 3'd7});
        wr(8'h3C, n);
        wr(8'hC3, n);
        wait_start(50);
        repeat (100) @(negedge clk);
        Tx_EN = 1'b0;
        if (start_q.size() > 0) while (cyc < start_q[0] + 820) @(negedge clk);
        chk1("dis_Tx_D", Tx_D, 1'b1);
        chk1("dis_BUSY", Tx_BUSY, 1'b1);
        chkn("dis_pending", exp_q.size(), 1);
        @(posedge clk); #1;
        Tx_EN = 1'b1; m = cyc;
        find_fall(20, fall);
        chkn("reenable_lat", fall - m, 2);
        wait_idle(2000);

        // Baud change mid-frame applies only to the next frame.
        start_q.delete();
        exp_q.push_back('{8'h96, 2'd0, 1'b0, 3'd7});
        exp_q.push_back('{8'h69, 2'd0, 1'b0, 3'd6});
        wr(8'h96, n);
        wr(8'h69, n);
        wait_start(50);
        repeat (200) @(negedge clk);
        baud_select = 3'd6;
        wait_idle(4000);
        chkn("baud_frames", start_q.size(), 2);
        if (start_q.size() == 2) chkn("old_baud_len", start_q[1] - start_q[0], 800);
        baud_select = 3'd7;

        // Reset pulse mid-DATA with a second byte queued.
        start_q.delete();
        exp_q.push_back('{8'hE7, 2'd0, 1'b0, 3'd7});
        exp_q.push_back('{8'h18, 2'd0, 1'b0, 3'd7});
        wr(8'hE7, n);
        wr(8'h18, n);
        wait_start(50);
        if (start_q.size() > 0) while (cyc < start_q[0] + 3 * 80) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_Tx_D", Tx_D, 1'b1);
        chk1("rst_BUSY", Tx_BUSY, 1'b0);
        chk1("rst_FULL", Tx_FULL, 1'b0);
        chk1("rst_OVF", Tx_OVF, 1'b0);
        exp_q.delete();
        repeat (50) @(negedge clk);
        chkn("rst_no_resume", start_q.size(), 1);
        exp_q.push_back('{8'h81, 2'd0, 1'b0, 3'd7});
        wr(8'h81, n);
        find_fall(50, fall);
        chkn("post_rst_lat", fall - n, 2);
        wait_idle(2000);

        // Random bursts: config held per burst, latched by the DUT at each pop.
        for (int b = 0; b < 5; b++) begin
            parity_mode = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            baud_select = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd6;
            nb = $urandom_range(1, 2);
            for (int i = 0; i < nb; i++) begin
                d = DB'($urandom);
                exp_q.push_back('{d, parity_mode, stop2, baud_select});
                wr(d, n);
            end
            wait_idle(6000);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
